ens_layer_skid_reg: RTL

ENS_LAYER_SKID_REG -- requirements
Module: ens_layer_skid_reg

---
 rtl/ens_pipe_pkg.sv | 13 +
 rtl/ens_sat_counter.sv | 31 +++
 rtl/ens_layer_skid_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/ens_pipe_pkg.sv
// Shared constants and FSM state encoding for the ensemble-layer pipeline blocks.
package ens_pipe_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ens_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high and sticks at all-ones.
module ens_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ens_layer_skid_reg.sv
// Two-entry skid register between ensemble layers; fully registered valid/ready.
// Define ENS_SKID_PERF_EN to add the saturating stall counter output stall_cnt.
module ens_layer_skid_reg
    import ens_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ENS_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_acc;
    logic             out_acc;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign in_acc  = in_valid && in_ready_q;
    assign out_acc = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_acc && out_acc) begin
                    main_d = in_data;
                end else if (in_acc) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef ENS_SKID_PERF_EN
    ens_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (out_valid_q && !out_ready),
        .cnt_o (stall_cnt)
    );
`endif

endmodule
